// File: rtl/l1c_data_nway_if.sv
// l1c_data_nway_if -- bundle of all CPU-side, memory-side and status signals
// of the l1c_data_nway cache. Signal names keep their i_/o_ prefixes as seen
// from the cache.
//
// Handshake rules (both sides):
//   - CPU side: i_cpu_req rises with a stable request and stays high with
//     stable i_cpu_we/addr/wdata/bweb until the cache pulses o_cpu_ready for
//     exactly one cycle. The requester drops i_cpu_req after that edge.
//   - Memory side: o_mem_req rises with stable o_mem_we/addr/wdata/bweb and
//     stays high, unchanged, until the cycle in which i_mem_ack is sampled
//     high. i_mem_ack is meaningless while o_mem_req is low.
//     i_mem_rdata is only sampled together with i_mem_ack on line reads.
//
// Modports:
//   slave  -- the cache (drives o_*, dbg_state)
//   master -- the CPU/memory environment (drives i_*)
interface l1c_data_nway_if;
  logic         i_cpu_req;
  logic         i_cpu_we;
  logic [31:0]  i_cpu_addr;
  logic [31:0]  i_cpu_wdata;
  logic [31:0]  i_cpu_bweb;
  logic         i_flush;
  logic         o_cpu_ready;
  logic [31:0]  o_cpu_rdata;
  logic         o_mem_req;
  logic         o_mem_we;
  logic [31:0]  o_mem_addr;
  logic [31:0]  o_mem_wdata;
  logic [31:0]  o_mem_bweb;
  logic         i_mem_ack;
  logic [127:0] i_mem_rdata;
  logic [15:0]  o_hit_cnt;
  logic [15:0]  o_miss_cnt;
  logic [2:0]   dbg_state;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_bweb, i_flush,
    input  i_mem_ack, i_mem_rdata,
    output o_cpu_ready, o_cpu_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bweb,
    output o_hit_cnt, o_miss_cnt, dbg_state
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_bweb, i_flush,
    output i_mem_ack, i_mem_rdata,
    input  o_cpu_ready, o_cpu_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bweb,
    input  o_hit_cnt, o_miss_cnt, dbg_state
  );
endinterface

// File: rtl/l1c_data_nway.sv
// l1c_data_nway -- N-way set-associative L1 data cache, 16-byte lines,
// read-allocate, write-through with no write-allocate, MRU-based victim pick.
//
// Ports:
//   clk  -- clock, all state on the rising edge
//   rst  -- asynchronous active-high reset
//   bus  -- l1c_data_nway_if.slave: CPU request/response, memory
//           request/ack/refill, hit/miss counters, dbg_state (FSM state)
//
// Parameters:
//   WAYS -- associativity (1, 2, 4, 8)
//   SETS -- number of sets (power of two, 2..256)
module l1c_data_nway #(
  parameter int WAYS = 2,
  parameter int SETS = 32
) (
  input  logic               clk,
  input  logic               rst,
  l1c_data_nway_if.slave     bus
);

  localparam int IDX = $clog2(SETS);
  localparam int TAG = 28 - IDX;
  localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    MEM_RD = 3'd2,
    FILL   = 3'd3,
    MEM_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t state;

  // Latched request
  logic         we_q;
  logic [31:0]  addr_q;
  logic [31:0]  wdata_q;
  logic [31:0]  bweb_q;
  logic [127:0] line_q;

  // Storage: tag/data are not reset, valid/MRU are.
  logic [TAG-1:0] tag_mem  [WAYS][SETS];
  logic [127:0]   data_mem [WAYS][SETS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WB-1:0]   mru_q   [SETS];

  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag;
  logic [1:0]     word;

  assign idx  = addr_q[3+IDX:4];
  assign tag  = addr_q[31:4+IDX];
  assign word = addr_q[3:2];

  assign bus.dbg_state = state;

  // Tag compare on the latched address
  logic [WAYS-1:0] hit_vec;
  logic [WB-1:0]   hit_way;
  logic            hit;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_mem[w][idx] == tag)) begin
        hit_vec[w] = 1'b1;
        hit_way    = WB'(w);
      end
    end
  end

  assign hit = |hit_vec;

  // Hit line, addressed word and the write-hit merged line
  logic [127:0] hit_line;
  logic [31:0]  hit_word;
  logic [31:0]  new_word;
  logic [127:0] merged_line;

  assign hit_line = data_mem[hit_way][idx];
  assign hit_word = hit_line[{word, 5'b0} +: 32];
  // bweb is active-low: a 0 bit takes the new data, a 1 bit keeps the old
  assign new_word = (hit_word & bweb_q) | (wdata_q & ~bweb_q);

  always_comb begin
    merged_line = hit_line;
    merged_line[{word, 5'b0} +: 32] = new_word;
  end

  // Victim: lowest invalid way, otherwise the way after the MRU one
  logic [WB:0]   mru_next;
  logic [WB-1:0] victim;
  logic          found_inv;

  always_comb begin
    mru_next  = {1'b0, mru_q[idx]} + 1'b1;
    victim    = (mru_next == (WB+1)'(WAYS)) ? '0 : mru_next[WB-1:0];
    found_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[idx][w]) begin
        victim    = WB'(w);
        found_inv = 1'b1;
      end
    end
  end

  // Tag/data arrays. Writes only happen in CHECK/FILL, which reset leaves
  // immediately, so these need no reset of their own.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      data_mem[victim][idx] <= line_q;
      tag_mem[victim][idx]  <= tag;
    end else if (state == CHECK && we_q && hit) begin
      data_mem[hit_way][idx] <= merged_line;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      bweb_q          <= '0;
      line_q          <= '0;
      bus.o_cpu_ready <= 1'b0;
      bus.o_cpu_rdata <= '0;
      bus.o_mem_req   <= 1'b0;
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_wdata <= '0;
      bus.o_mem_bweb  <= '0;
      bus.o_hit_cnt   <= '0;
      bus.o_miss_cnt  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        mru_q[s]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_flush) begin
            // Flush wins over a simultaneous request; the request is
            // taken on a later cycle since it stays asserted.
            for (int s = 0; s < SETS; s++) begin
              valid_q[s] <= '0;
              mru_q[s]   <= '0;
            end
          end else if (bus.i_cpu_req) begin
            we_q    <= bus.i_cpu_we;
            addr_q  <= bus.i_cpu_addr;
            wdata_q <= bus.i_cpu_wdata;
            bweb_q  <= bus.i_cpu_bweb;
            state   <= CHECK;
          end
        end

        CHECK: begin
          if (hit) begin
            if (bus.o_hit_cnt != 16'hFFFF) bus.o_hit_cnt <= bus.o_hit_cnt + 16'd1;
            mru_q[idx] <= hit_way;
          end else begin
            if (bus.o_miss_cnt != 16'hFFFF) bus.o_miss_cnt <= bus.o_miss_cnt + 16'd1;
          end

          if (!we_q) begin
            if (hit) begin
              bus.o_cpu_rdata <= hit_word;
              bus.o_cpu_ready <= 1'b1;
              state           <= RESP;
            end else begin
              bus.o_mem_req  <= 1'b1;
              bus.o_mem_we   <= 1'b0;
              bus.o_mem_addr <= {addr_q[31:4], 4'b0000};
              state          <= MEM_RD;
            end
          end else begin
            // Write-through; the cached copy (if any) is merged above
            bus.o_mem_req   <= 1'b1;
            bus.o_mem_we    <= 1'b1;
            bus.o_mem_addr  <= addr_q;
            bus.o_mem_wdata <= wdata_q;
            bus.o_mem_bweb  <= bweb_q;
            state           <= MEM_WR;
          end
        end

        MEM_RD: begin
          if (bus.i_mem_ack) begin
            line_q        <= bus.i_mem_rdata;
            bus.o_mem_req <= 1'b0;
            state         <= FILL;
          end
        end

        FILL: begin
          valid_q[idx][victim] <= 1'b1;
          mru_q[idx]           <= victim;
          bus.o_cpu_rdata      <= line_q[{word, 5'b0} +: 32];
          bus.o_cpu_ready      <= 1'b1;
          state                <= RESP;
        end

        MEM_WR: begin
          if (bus.i_mem_ack) begin
            bus.o_mem_req   <= 1'b0;
            bus.o_cpu_ready <= 1'b1;
            state           <= RESP;
          end
        end

        RESP: begin
          bus.o_cpu_ready <= 1'b0;
          state           <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1c_data_nway.sv
module tb_l1c_data_nway;

  logic clk;
  logic rst;

  l1c_data_nway_if bus ();

  l1c_data_nway #(.WAYS(2), .SETS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec;
  int n_fail;

  // One access: inputs plus expected results
  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  bweb;
    logic [127:0] refill;
    int           ack_delay;
    logic         exp_mem;
    logic [31:0]  exp_mem_addr;
    logic [31:0]  exp_rdata;
    logic [15:0]  exp_hit;
    logic [15:0]  exp_miss;
  } vec_t;

  localparam logic [127:0] L1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] LA = 128'hA3A3_A3A3_A2A2_A2A2_A1A1_A1A1_A0A0_A0A0;
  localparam logic [127:0] LB = 128'hB3B3_B3B3_B2B2_B2B2_B1B1_B1B1_B0B0_B0B0;
  localparam logic [127:0] LC = 128'hC3C3_C3C3_C2C2_C2C2_C1C1_C1C1_C0C0_C0C0;
  localparam logic [127:0] LD = 128'hD3D3_D3D3_D2D2_D2D2_D1D1_D1D1_D0D0_D0D0;
  localparam logic [127:0] LE = 128'hE3E3_E3E3_E2E2_E2E2_E1E1_E1E1_E0E0_E0E0;
  localparam logic [127:0] LF = 128'hF3F3_F3F3_F2F2_F2F2_F1F1_F1F1_F0F0_F0F0;

  vec_t vecs [14];

  task automatic check(input int id, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got %h expected %h", id, what, act, exp);
    end
  endtask

  // Drive one request and service the memory side until o_cpu_ready.
  task automatic do_access(input vec_t v, input logic pre_flush, input logic flush_mid,
                           output logic saw_mem, output logic m_we,
                           output logic [31:0] m_addr, output logic [31:0] m_wdata,
                           output logic [31:0] m_bweb, output logic [31:0] rdata,
                           output int lat, output logic stable_bad,
                           output logic pulse_bad, output logic timeout,
                           output logic flush_idle_bad);
    int k;
    int wait_cnt;
    logic done;
    saw_mem = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_bweb = '0;
    rdata = '0; lat = 0; stable_bad = 1'b0; pulse_bad = 1'b0;
    flush_idle_bad = 1'b0; wait_cnt = 0; done = 1'b0; k = 0;

    @(negedge clk);
    bus.i_cpu_req   = 1'b1;
    bus.i_cpu_we    = v.we;
    bus.i_cpu_addr  = v.addr;
    bus.i_cpu_wdata = v.wdata;
    bus.i_cpu_bweb  = v.bweb;
    if (pre_flush) begin
      bus.i_flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_flush = 1'b0;
      flush_idle_bad = (bus.dbg_state != 3'd0);
    end
    @(posedge clk);  // acceptance edge

    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      bus.i_mem_ack = 1'b0;
      bus.i_flush   = flush_mid && bus.o_mem_req;
      if (bus.o_cpu_ready) begin
        done  = 1'b1;
        rdata = bus.o_cpu_rdata;
        lat   = k;
      end else if (bus.o_mem_req) begin
        if (!saw_mem) begin
          saw_mem = 1'b1;
          m_we    = bus.o_mem_we;
          m_addr  = bus.o_mem_addr;
          m_wdata = bus.o_mem_wdata;
          m_bweb  = bus.o_mem_bweb;
        end else if (bus.o_mem_we !== m_we || bus.o_mem_addr !== m_addr ||
                     bus.o_mem_wdata !== m_wdata || bus.o_mem_bweb !== m_bweb) begin
          stable_bad = 1'b1;
        end
        if (wait_cnt >= v.ack_delay) begin
          bus.i_mem_ack   = 1'b1;
          bus.i_mem_rdata = v.refill;
        end
        wait_cnt++;
      end
    end
    timeout = !done;
    bus.i_flush = 1'b0;
    @(posedge clk);
    #1;
    bus.i_cpu_req = 1'b0;
    bus.i_mem_ack = 1'b0;
    @(negedge clk);
    pulse_bad = bus.o_cpu_ready;
  endtask

  task automatic apply(input int id, input vec_t v, input logic pre_flush,
                       input logic flush_mid);
    logic saw_mem, m_we, stable_bad, pulse_bad, timeout, flush_idle_bad;
    logic [31:0] m_addr, m_wdata, m_bweb, rdata;
    int lat;
    do_access(v, pre_flush, flush_mid, saw_mem, m_we, m_addr, m_wdata, m_bweb,
              rdata, lat, stable_bad, pulse_bad, timeout, flush_idle_bad);
    check(id, "timeout", {31'd0, timeout}, 32'd0);
    check(id, "mem_req_seen", {31'd0, saw_mem}, {31'd0, v.exp_mem});
    if (v.exp_mem) begin
      check(id, "mem_addr", m_addr, v.exp_mem_addr);
      check(id, "mem_we", {31'd0, m_we}, {31'd0, v.we});
      check(id, "mem_stable", {31'd0, stable_bad}, 32'd0);
      if (v.we) begin
        check(id, "mem_wdata", m_wdata, v.wdata);
        check(id, "mem_bweb", m_bweb, v.bweb);
      end
    end
    if (!v.exp_mem && !v.we) check(id, "hit_latency", lat, 32'd2);
    if (pre_flush) check(id, "flush_stays_idle", {31'd0, flush_idle_bad}, 32'd0);
    check(id, "rdata", rdata, v.exp_rdata);
    check(id, "hit_cnt", {16'd0, bus.o_hit_cnt}, {16'd0, v.exp_hit});
    check(id, "miss_cnt", {16'd0, bus.o_miss_cnt}, {16'd0, v.exp_miss});
    check(id, "ready_one_cycle", {31'd0, pulse_bad}, 32'd0);
  endtask

  task automatic check_all_zero(input int id);
    check(id, "rst_cpu_ready", {31'd0, bus.o_cpu_ready}, 32'd0);
    check(id, "rst_cpu_rdata", bus.o_cpu_rdata, 32'd0);
    check(id, "rst_mem_req", {31'd0, bus.o_mem_req}, 32'd0);
    check(id, "rst_mem_addr", bus.o_mem_addr, 32'd0);
    check(id, "rst_hit_cnt", {16'd0, bus.o_hit_cnt}, 32'd0);
    check(id, "rst_miss_cnt", {16'd0, bus.o_miss_cnt}, 32'd0);
    check(id, "rst_state", {29'd0, bus.dbg_state}, 32'd0);
  endtask

  initial begin : main
    vec_t v;
    int k;
    n_vec = 0;
    n_fail = 0;

    // Fields: we, addr, wdata, bweb, refill, ack_delay,
    //         exp_mem, exp_mem_addr, exp_rdata, exp_hit, exp_miss
    vecs[0]  = '{1'b0, 32'h0000_0014, 32'h0, 32'hFFFF_FFFF, L1, 2, 1'b1, 32'h0000_0010, 32'h2222_2222, 16'd0, 16'd1};
    vecs[1]  = '{1'b0, 32'h0000_0014, 32'h0, 32'hFFFF_FFFF, '0, 0, 1'b0, 32'h0,          32'h2222_2222, 16'd1, 16'd1};
    vecs[2]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 32'hFFFF_0000, '0, 1, 1'b1, 32'h0000_0014, 32'h2222_2222, 16'd2, 16'd1};
    vecs[3]  = '{1'b0, 32'h0000_0014, 32'h0, 32'hFFFF_FFFF, '0, 0, 1'b0, 32'h0,          32'h2222_5678, 16'd3, 16'd1};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, LA, 0, 1'b1, 32'h0000_0000, 32'hA0A0_A0A0, 16'd3, 16'd2};
    vecs[5]  = '{1'b0, 32'h0000_0200, 32'h0, 32'hFFFF_FFFF, LB, 0, 1'b1, 32'h0000_0200, 32'hB0B0_B0B0, 16'd3, 16'd3};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, '0, 0, 1'b0, 32'h0,          32'hA0A0_A0A0, 16'd4, 16'd3};
    vecs[7]  = '{1'b0, 32'h0000_0400, 32'h0, 32'hFFFF_FFFF, LC, 0, 1'b1, 32'h0000_0400, 32'hC0C0_C0C0, 16'd4, 16'd4};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, '0, 0, 1'b0, 32'h0,          32'hA0A0_A0A0, 16'd5, 16'd4};
    vecs[9]  = '{1'b0, 32'h0000_0200, 32'h0, 32'hFFFF_FFFF, LB, 0, 1'b1, 32'h0000_0200, 32'hB0B0_B0B0, 16'd5, 16'd5};
    vecs[10] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000, '0, 3, 1'b1, 32'h0000_1000, 32'hB0B0_B0B0, 16'd5, 16'd6};
    vecs[11] = '{1'b0, 32'h0000_1000, 32'h0, 32'hFFFF_FFFF, LD, 0, 1'b1, 32'h0000_1000, 32'hD0D0_D0D0, 16'd5, 16'd7};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, LA, 0, 1'b1, 32'h0000_0000, 32'hA0A0_A0A0, 16'd5, 16'd8};
    vecs[13] = '{1'b0, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, '0, 0, 1'b0, 32'h0,          32'hA0A0_A0A0, 16'd6, 16'd8};

    bus.i_cpu_req   = 1'b0;
    bus.i_cpu_we    = 1'b0;
    bus.i_cpu_addr  = '0;
    bus.i_cpu_wdata = '0;
    bus.i_cpu_bweb  = '1;
    bus.i_flush     = 1'b0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero(0);
    rst = 1'b0;

    // Table: miss/hit, write-hit merge, MRU eviction, write-miss no-allocate
    for (int i = 0; i < 14; i++) apply(i + 1, vecs[i], 1'b0, 1'b0);

    // Flush and request in the same IDLE cycle: flush first, then a miss
    v = '{1'b0, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, LA, 0, 1'b1, 32'h0000_0000, 32'hA0A0_A0A0, 16'd6, 16'd9};
    apply(20, v, 1'b1, 1'b0);

    // Flush held during MEM_RD is ignored: the line fills and stays valid
    v = '{1'b0, 32'h0000_0030, 32'h0, 32'hFFFF_FFFF, LE, 2, 1'b1, 32'h0000_0030, 32'hE0E0_E0E0, 16'd6, 16'd10};
    apply(21, v, 1'b0, 1'b1);
    v = '{1'b0, 32'h0000_0030, 32'h0, 32'hFFFF_FFFF, '0, 0, 1'b0, 32'h0, 32'hE0E0_E0E0, 16'd7, 16'd10};
    apply(22, v, 1'b0, 1'b0);
    v = '{1'b0, 32'h0000_0004, 32'h0, 32'hFFFF_FFFF, '0, 0, 1'b0, 32'h0, 32'hA1A1_A1A1, 16'd8, 16'd10};
    apply(23, v, 1'b0, 1'b0);

    // Reset while MEM_RD waits for ack
    @(negedge clk);
    bus.i_cpu_req  = 1'b1;
    bus.i_cpu_we   = 1'b0;
    bus.i_cpu_addr = 32'h0000_0800;
    k = 0;
    while (!bus.o_mem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(30, "mem_req_before_rst", {31'd0, bus.o_mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check(30, "mem_req_drops_on_rst", {31'd0, bus.o_mem_req}, 32'd0);
    @(negedge clk);
    bus.i_cpu_req = 1'b0;
    check_all_zero(31);
    rst = 1'b0;

    v = '{1'b0, 32'h0000_0800, 32'h0, 32'hFFFF_FFFF, LF, 0, 1'b1, 32'h0000_0800, 32'hF0F0_F0F0, 16'd0, 16'd1};
    apply(32, v, 1'b0, 1'b0);
    v = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 32'h00FF_00FF, '0, 0, 1'b1, 32'h0000_1000, 32'hF0F0_F0F0, 16'd0, 16'd2};
    apply(33, v, 1'b0, 1'b0);
    v = '{1'b0, 32'h0000_1000, 32'h0, 32'hFFFF_FFFF, LD, 1, 1'b1, 32'h0000_1000, 32'hD0D0_D0D0, 16'd0, 16'd3};
    apply(34, v, 1'b0, 1'b0);
    v = '{1'b0, 32'h0000_080C, 32'h0, 32'hFFFF_FFFF, '0, 0, 1'b0, 32'h0, 32'hF3F3_F3F3, 16'd1, 16'd3};
    apply(35, v, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/l1c_data_nway.md
L1C_DATA_NWAY -- requirements
Module: l1c_data_nway

Interface
REQ-001 The block SHALL have parameter WAYS, default 2, associativity; legal values 1, 2, 4, 8.
REQ-002 The block SHALL have parameter SETS, default 32, set count; power of two, 2..256; IDX=log2(SETS), TAG=28-IDX.
REQ-003 The block SHALL have the ports below (clock and reset first); one clock, reset asynchronous and active-high:
  clk  in  1  clock, all state on rising edge
  rst  in  1  asynchronous active-high reset
  i_cpu_req  in  1  request, held high until o_cpu_ready
  i_cpu_we  in  1  1=write, 0=read
  i_cpu_addr  in  32  byte address; [3:2] word, [3+IDX:4] index, [31:4+IDX] tag
  i_cpu_wdata  in  32  write data
  i_cpu_bweb  in  32  per-bit write enable, active-low
  i_flush  in  1  invalidate all lines
  o_cpu_ready  out  1  one-cycle completion pulse
  o_cpu_rdata  out  32  read data, valid with o_cpu_ready on reads
  o_mem_req  out  1  memory request, held until i_mem_ack
  o_mem_we  out  1  1=word write, 0=line read
  o_mem_addr  out  32  reads: line-aligned ([3:0]=0); writes: cpu address
  o_mem_wdata  out  32  write data
  o_mem_bweb  out  32  write bit enables, active-low
  i_mem_ack  in  1  completes the current memory request
  i_mem_rdata  in  128  refill line, valid with i_mem_ack; word n at [32n+31:32n]
  o_hit_cnt  out  16  saturating hit counter
  o_miss_cnt  out  16  saturating miss counter

Function
REQ-004 The FSM SHALL have states IDLE, CHECK, MEM_RD, FILL, MEM_WR, RESP.
REQ-005 IDLE: i_flush=1 SHALL clear all valid bits and MRU pointers in one cycle and stay IDLE; flush SHALL win over a simultaneous i_cpu_req.
REQ-006 IDLE with i_cpu_req=1, i_flush=0 SHALL latch addr/we/wdata/bweb and go to CHECK.
REQ-007 CHECK: hit = any way valid with matching tag in the indexed set; at most one way SHALL hit.
REQ-008 Read hit SHALL set set-MRU to the hit way, latch the addressed word, go RESP; o_cpu_ready SHALL assert 2 cycles after acceptance.
REQ-009 Read miss SHALL go MEM_RD; MEM_RD SHALL drive o_mem_req=1, o_mem_we=0, line-aligned address until i_mem_ack (ack in first MEM_RD cycle allowed), then go FILL.
REQ-010 Victim SHALL be the lowest-numbered invalid way, else (MRU+1) mod WAYS.
REQ-011 FILL SHALL write the line, tag and valid=1 into the victim, set MRU=victim, select the addressed word into o_cpu_rdata, go RESP.
REQ-012 Write (hit or miss) SHALL go MEM_WR; on hit the cached word SHALL be updated in CHECK only on bits where i_cpu_bweb=0, and MRU set to the hit way.
REQ-013 Write miss SHALL NOT allocate or change any valid, tag or MRU state.
REQ-014 MEM_WR SHALL drive o_mem_req=1, o_mem_we=1, o_mem_addr/wdata/bweb from latched request until i_mem_ack, then go RESP.
REQ-015 RESP SHALL assert o_cpu_ready for exactly one cycle and return to IDLE; o_cpu_rdata SHALL hold until the next read completes.
REQ-016 o_mem_* SHALL remain stable while o_mem_req=1; i_mem_ack SHALL be ignored while o_mem_req=0.
REQ-017 Each CHECK SHALL increment o_hit_cnt on hit else o_miss_cnt; both SHALL saturate at 16'hFFFF.
REQ-018 i_flush outside IDLE SHALL be ignored.

Reset
REQ-019 rst=1 SHALL immediately force IDLE, all outputs to 0, all valid bits and MRU pointers to 0, counters to 0; tag/data contents need no reset.
REQ-020 Reset during MEM_RD/MEM_WR SHALL drop o_mem_req in the same cycle and leave no line valid.

Verification (WAYS=2, SETS=32)
REQ-021 Read 0x0000_0014 after reset -> MEM_RD addr 0x0000_0010; ack rdata 128'h4444_4444_3333_3333_2222_2222_1111_1111 -> rdata 0x2222_2222, miss_cnt=1; re-read -> no o_mem_req, ready 2 cycles after accept, hit_cnt=1.
REQ-022 Write 0x1234_5678, bweb 0xFFFF_0000 to cached 0x0000_0014 -> mem write addr 0x0000_0014 same bweb; re-read hits returning 0x2222_5678.
REQ-023 Reads 0x0000_0000 (A), 0x0000_0200 (B), A, then 0x0000_0400 (C) -> C evicts B; then A hits, B misses.
REQ-024 Write to 0x0000_1000 after reset -> one mem write, miss_cnt=1; read 0x0000_1000 then misses (no allocate).
REQ-025 i_flush and i_cpu_req in same IDLE cycle after A cached -> flush taken, req served next cycle as miss.
REQ-026 rst pulse while MEM_RD awaits ack -> o_mem_req=0 same cycle; subsequent read of same address misses.
